mailbox_rx_port: RTL and testbench
==================================

Name: mailbox_rx_port

Overview:
- Receive-side end of the inter-CPU mailbox: drains one destination CPU's message FIFO and presents each message to that CPU.
- Pops FIFO_DATA-wide entries from a first-word-fall-through-free FIFO (1-cycle read latency) and unpacks them into data, address and header fields.
- Hands each message to the CPU over a valid/ready handshake, with a level interrupt, a delivered-message counter and a sticky error flag.
- One instance per CPU; N_NUMB_CPU instances sit beside the mailbox FIFO array.

Parameters:
- W_WIDTH_SYS, 32, message data width (mailbox_pkg).
- WIDTH_ADDR, 32, message address width (mailbox_pkg).
- N_NUMB_CPU, 4, number of CPUs; legal source IDs are 0..N_NUMB_CPU-1.
- CPU_ID, 0, ID of the CPU this port serves.
- FIFO_DATA, W_WIDTH_SYS+WIDTH_ADDR+32, FIFO entry width. Layout is [FIFO_DATA-1 -: 32] header, then address, then data in the LSBs. Header bits: [7:0] src id, [15:8] tag, [31:16] reserved.
- SRC_W, $clog2(N_NUMB_CPU), source ID output width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty_i  in  1  destination FIFO empty.
- fifo_rd_o  out  1  FIFO pop request; data is valid on fifo_data_i the following cycle.
- fifo_data_i  in  FIFO_DATA  popped entry.
- msg_valid_o  out  1  message available to the CPU.
- msg_ready_i  in  1  CPU accepts the message.
- msg_data_o  out  W_WIDTH_SYS  message payload.
- msg_addr_o  out  WIDTH_ADDR  message address field.
- msg_src_o  out  SRC_W  sender CPU ID.
- msg_tag_o  out  8  sender tag.
- irq_o  out  1  interrupt, level.
- rx_count_o  out  16  delivered-message counter.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including message registers, rx_count_o and err_o.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if !fifo_empty_i, drive fifo_rd_o=1 for one cycle and go to WAIT.
  - WAIT: capture fifo_data_i into the output registers, then go to HOLD. With the macro enabled, a dropped message (see Optional Feature) instead returns to IDLE.
  - HOLD: msg_valid_o=1. Outputs stay stable until msg_valid_o && msg_ready_i.
    - On handshake: rx_count_o+1.
    - If !fifo_empty_i in the handshake cycle: fifo_rd_o=1 in that same cycle and go to WAIT.
    - Otherwise go to IDLE.
- fifo_rd_o is never asserted outside IDLE/HOLD-handshake and never while fifo_empty_i=1, so the FIFO is never underflowed.
- Latency: fifo_empty_i falling (sampled in IDLE) gives fifo_rd_o in cycle 0 and msg_valid_o in cycle 2.
- Throughput: back-to-back, with msg_ready_i held high, one message per 2 cycles.
- irq_o = msg_valid_o, registered with it. It is not asserted for dropped messages.
- rx_count_o wraps modulo 2^16 (0xFFFF+1 gives 0x0000).
- Self-message (src == CPU_ID): delivered normally. No error is flagged.
- err_o is set by any error event and held until err_clr_i.
  - If err_clr_i and a new error event occur in the same cycle, the set wins.
- msg_ready_i while msg_valid_o=0 is ignored.
- Reset mid-operation: a pending popped entry is lost. The FIFO owner is responsible for that; no replay.

Optional Feature:
- Macro: MAILBOX_RX_SRC_CHECK_EN.
- Defined:
  - In WAIT, if header src id >= N_NUMB_CPU, the message is dropped: no msg_valid_o, no count, err_o set.
  - FSM returns to IDLE and pops the next entry if one is present.
  - Reserved header bits [31:16] != 0 also set err_o, but the message is still delivered.
- Undefined:
  - No checks; msg_src_o = header[SRC_W-1:0] truncated.
  - err_o stays tied to 0.

Test Plan:
- Reset, then one entry with src=2, tag=0x5A, addr=0x1000_0040, data=0xDEAD_BEEF, msg_ready_i held 0:
  - fifo_rd_o pulses once.
  - msg_valid_o and irq_o rise 2 cycles later; fields match.
  - Fields are stable for 10 cycles; ready then gives rx_count_o=1 and irq_o low the next cycle.
- 4 queued entries, msg_ready_i=1: delivered in order at a 2-cycle cadence; 4 fifo_rd_o pulses total; rx_count_o=4; no rd while empty.
- Backpressure: ready low for 5 cycles with the FIFO non-empty: no extra fifo_rd_o; outputs constant.
- Counter preloaded near wrap (drive 65536 deliveries, or force): rx_count_o goes 0xFFFF to 0x0000.
- MAILBOX_RX_SRC_CHECK_EN, entry src=7 followed by a valid entry src=1:
  - First entry: no msg_valid_o, err_o=1, count unchanged.
  - Second entry delivered.
  - err_clr_i clears err_o; err_clr_i coincident with a new bad src leaves err_o=1.
- Assert rst_n low while in HOLD: all outputs 0 asynchronously; after release the FSM is in IDLE and resumes popping the remaining entries.

Source files
------------

// File: rtl/mailbox_rx_port.sv
// Receive end of the inter-CPU mailbox: pops one FIFO entry at a time and holds it for the CPU.
// Optional source-ID / reserved-header checking is enabled with `define MAILBOX_RX_SRC_CHECK_EN.
module mailbox_rx_port #(
   parameter int W_WIDTH_SYS = 32,
   parameter int WIDTH_ADDR  = 32,
   parameter int N_NUMB_CPU  = 4,
   parameter int CPU_ID      = 0,
   parameter int FIFO_DATA   = W_WIDTH_SYS + WIDTH_ADDR + 32,
   parameter int SRC_W       = $clog2(N_NUMB_CPU)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fifo_empty_i,
   output logic                   fifo_rd_o,
   input  logic [FIFO_DATA-1:0]   fifo_data_i,
   output logic                   msg_valid_o,
   input  logic                   msg_ready_i,
   output logic [W_WIDTH_SYS-1:0] msg_data_o,
   output logic [WIDTH_ADDR-1:0]  msg_addr_o,
   output logic [SRC_W-1:0]       msg_src_o,
   output logic [7:0]             msg_tag_o,
   output logic                   irq_o,
   output logic [15:0]            rx_count_o,
   output logic                   err_o,
   input  logic                   err_clr_i
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   if (CPU_ID < 0 || CPU_ID >= N_NUMB_CPU) begin : g_bad_cpu_id
      $error("mailbox_rx_port: CPU_ID outside 0..N_NUMB_CPU-1");
   end

   state_t                 state_q;
   logic                   run_q;
   logic                   msg_valid_q;
   logic                   irq_q;
   logic [W_WIDTH_SYS-1:0] msg_data_q;
   logic [WIDTH_ADDR-1:0]  msg_addr_q;
   logic [SRC_W-1:0]       msg_src_q;
   logic [7:0]             msg_tag_q;
   logic [15:0]            rx_count_q;
   logic [15:0]            rx_count_d;

   logic [31:0] hdr;
   logic        handshake;
   logic        pop;
   logic        src_bad;

   assign hdr        = fifo_data_i[FIFO_DATA-1 -: 32];
   assign handshake  = msg_valid_q & msg_ready_i;
   assign rx_count_d = rx_count_q + 16'd1;

   // run_q holds off popping until the first edge after reset release, so a FIFO
   // that is non-empty during reset is never popped.
   assign pop = run_q & ~fifo_empty_i &
                ((state_q == S_IDLE) | ((state_q == S_HOLD) & handshake));

`ifdef MAILBOX_RX_SRC_CHECK_EN
   localparam logic [7:0] SRC_LIMIT = 8'(N_NUMB_CPU);

   logic err_evt;
   logic err_q;
   logic err_d;

   assign src_bad = (hdr[7:0] >= SRC_LIMIT);
   assign err_evt = (state_q == S_WAIT) & (src_bad | (|hdr[31:16]));

   // A new error event outranks a simultaneous clear.
   always_comb begin
      err_d = err_q;
      if (err_clr_i) err_d = 1'b0;
      if (err_evt)   err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err_o = err_q;
`else
   logic unused_hdr;

   assign src_bad    = 1'b0;
   assign unused_hdr = ^{hdr[31:SRC_W], err_clr_i};
   assign err_o      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         run_q       <= 1'b0;
         msg_valid_q <= 1'b0;
         irq_q       <= 1'b0;
         msg_data_q  <= '0;
         msg_addr_q  <= '0;
         msg_src_q   <= '0;
         msg_tag_q   <= '0;
         rx_count_q  <= '0;
      end else begin
         run_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (pop) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (src_bad) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q     <= S_HOLD;
                  msg_valid_q <= 1'b1;
                  irq_q       <= 1'b1;
                  msg_data_q  <= fifo_data_i[W_WIDTH_SYS-1:0];
                  msg_addr_q  <= fifo_data_i[W_WIDTH_SYS +: WIDTH_ADDR];
                  msg_src_q   <= hdr[SRC_W-1:0];
                  msg_tag_q   <= hdr[15:8];
               end
            end
            S_HOLD: begin
               if (handshake) begin
                  msg_valid_q <= 1'b0;
                  irq_q       <= 1'b0;
                  rx_count_q  <= rx_count_d;
                  state_q     <= pop ? S_WAIT : S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fifo_rd_o   = pop;
   assign msg_valid_o = msg_valid_q;
   assign irq_o       = irq_q;
   assign msg_data_o  = msg_data_q;
   assign msg_addr_o  = msg_addr_q;
   assign msg_src_o   = msg_src_q;
   assign msg_tag_o   = msg_tag_q;
   assign rx_count_o  = rx_count_q;

endmodule

// File: tb/tb_mailbox_rx_port.sv
// Bench for mailbox_rx_port: behavioural FIFO, expected-message queue checked by a monitor,
// plus directed latency / backpressure / wrap / error / reset checks.
module tb_mailbox_rx_port;

   localparam int FD = 96;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      logic [1:0]  src;
      logic [7:0]  tag;
   } msg_t;

   logic          clk;
   logic          rst_n;
   logic          fifo_empty_i;
   logic          fifo_rd_o;
   logic [FD-1:0] fifo_data_i;
   logic          msg_valid_o;
   logic          msg_ready_i;
   logic [31:0]   msg_data_o;
   logic [31:0]   msg_addr_o;
   logic [1:0]    msg_src_o;
   logic [7:0]    msg_tag_o;
   logic          irq_o;
   logic [15:0]   rx_count_o;
   logic          err_o;
   logic          err_clr_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rd_cnt = 0;

   logic [FD-1:0] fifo_q[$];
   msg_t          exp_q[$];
   int            hs_cyc[$];

   mailbox_rx_port dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
      .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
      .msg_data_o(msg_data_o), .msg_addr_o(msg_addr_o),
      .msg_src_o(msg_src_o), .msg_tag_o(msg_tag_o),
      .irq_o(irq_o), .rx_count_o(rx_count_o),
      .err_o(err_o), .err_clr_i(err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_msg(input logic [7:0] src, input logic [7:0] tag, input logic [15:0] rsv,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit deliver, input logic [1:0] exp_src);
      msg_t m;
      fifo_q.push_back({rsv, tag, src, addr, data});
      if (deliver) begin
         m.data = data; m.addr = addr; m.src = exp_src; m.tag = tag;
         exp_q.push_back(m);
      end
   endtask

   task automatic wait_count(input string name, input logic [15:0] tgt, input int budget);
      int n = 0;
      while (rx_count_o !== tgt && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      chk(name, rx_count_o, tgt);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (msg_valid_o !== 1'b1 && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      chk(name, msg_valid_o, 1'b1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_valid"}, msg_valid_o, 0);
      chk({pfx, "_irq"},   irq_o, 0);
      chk({pfx, "_rd"},    fifo_rd_o, 0);
      chk({pfx, "_data"},  msg_data_o, 0);
      chk({pfx, "_addr"},  msg_addr_o, 0);
      chk({pfx, "_src"},   msg_src_o, 0);
      chk({pfx, "_tag"},   msg_tag_o, 0);
      chk({pfx, "_count"}, rx_count_o, 0);
      chk({pfx, "_err"},   err_o, 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: one-cycle read latency, flags an underflowing pop
   always @(posedge clk) begin
      if (rst_n && fifo_rd_o) begin
         rd_cnt <= rd_cnt + 1;
         total++;
         if (fifo_q.size() == 0 || fifo_empty_i) begin
            bad++;
            $display("FAIL rd_underflow: rd while empty (size %0d) cycle %0d", fifo_q.size(), cyc);
         end else begin
            fifo_data_i <= fifo_q.pop_front();
         end
      end
   end

   always @(negedge clk) begin
      #1;
      fifo_empty_i = (fifo_q.size() == 0);
   end

   // Monitor: every handshake must match the head of the expected queue
   always @(negedge clk) begin
      msg_t e;
      #3;
      if (rst_n && msg_valid_o) begin
         chk("irq_eq_valid", irq_o, 1'b1);
         if (msg_ready_i) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_msg: data %0h with nothing expected", msg_data_o);
            end else begin
               e = exp_q.pop_front();
               $display("msg: src=%0d tag=%h addr=%h data=%h count_before=%0d",
                        msg_src_o, msg_tag_o, msg_addr_o, msg_data_o, rx_count_o);
               chk("hs_data", msg_data_o, e.data);
               chk("hs_addr", msg_addr_o, e.addr);
               chk("hs_src",  msg_src_o,  e.src);
               chk("hs_tag",  msg_tag_o,  e.tag);
            end
         end
      end
   end

   initial begin
      fifo_empty_i = 1'b1;
      fifo_data_i  = '0;
      rst_n        = 1'b0;
      msg_ready_i  = 1'b0;
      err_clr_i    = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // single message, latency and hold under ready=0
      @(negedge clk);
      push_msg(8'd2, 8'h5A, 16'h0, 32'h1000_0040, 32'hDEAD_BEEF, 1, 2'd2);
      #2;
      chk("lat_rd_c0", fifo_rd_o, 1);
      chk("lat_valid_c0", msg_valid_o, 0);
      @(negedge clk); #2;
      chk("lat_rd_c1", fifo_rd_o, 0);
      chk("lat_valid_c1", msg_valid_o, 0);
      @(negedge clk); #2;
      chk("lat_valid_c2", msg_valid_o, 1);
      chk("lat_irq_c2", irq_o, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         chk("hold_data", msg_data_o, 32'hDEAD_BEEF);
         chk("hold_addr", msg_addr_o, 32'h1000_0040);
         chk("hold_src",  msg_src_o, 2'd2);
         chk("hold_tag",  msg_tag_o, 8'h5A);
         chk("hold_valid", msg_valid_o, 1);
      end
      @(negedge clk);
      msg_ready_i = 1'b1;
      @(negedge clk);
      msg_ready_i = 1'b0;
      #2;
      chk("t1_count", rx_count_o, 16'd1);
      chk("t1_irq_low", irq_o, 0);
      chk("t1_rd_total", rd_cnt, 1);

      // four back-to-back messages
      @(negedge clk);
      hs_cyc.delete();
      msg_ready_i = 1'b1;
      push_msg(8'd0, 8'h11, 16'h0, 32'hA000_0000, 32'h0000_0001, 1, 2'd0);
      push_msg(8'd1, 8'h22, 16'h0, 32'hA000_0004, 32'h0000_0002, 1, 2'd1);
      push_msg(8'd3, 8'h33, 16'h0, 32'hA000_0008, 32'h0000_0003, 1, 2'd3);
      push_msg(8'd2, 8'h44, 16'h0, 32'hA000_000C, 32'h0000_0004, 1, 2'd2);
      wait_count("t2_count", 16'd5, 60);
      chk("t2_rd_total", rd_cnt, 5);
      chk("t2_hs_n", hs_cyc.size(), 4);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("t2_cadence", hs_cyc[i] - hs_cyc[i-1], 2);

      // backpressure with FIFO non-empty
      @(negedge clk);
      msg_ready_i = 1'b0;
      push_msg(8'd1, 8'h77, 16'h0, 32'hB000_0000, 32'h1234_5678, 1, 2'd1);
      push_msg(8'd3, 8'h88, 16'h0, 32'hB000_0010, 32'h8765_4321, 1, 2'd3);
      wait_valid("t3_valid", 20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #2;
         chk("bp_rd_total", rd_cnt, 6);
         chk("bp_data", msg_data_o, 32'h1234_5678);
         chk("bp_tag", msg_tag_o, 8'h77);
      end
      @(negedge clk);
      msg_ready_i = 1'b1;
      wait_count("t3_count", 16'd7, 60);

      // counter wrap
      @(negedge clk);
      msg_ready_i = 1'b0;
      force dut.rx_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.rx_count_q;
      #2;
      chk("wrap_preload", rx_count_o, 16'hFFFE);
      @(negedge clk);
      msg_ready_i = 1'b1;
      push_msg(8'd0, 8'hC1, 16'h0, 32'hC000_0000, 32'hCAFE_0001, 1, 2'd0);
      push_msg(8'd1, 8'hC2, 16'h0, 32'hC000_0004, 32'hCAFE_0002, 1, 2'd1);
      wait_count("wrap_ffff", 16'hFFFF, 40);
      wait_count("wrap_0000", 16'h0000, 40);

`ifdef MAILBOX_RX_SRC_CHECK_EN
      // bad source dropped, err sticky, clear, set-wins-over-clear, reserved bits
      @(negedge clk);
      push_msg(8'd7, 8'hE7, 16'h0, 32'hE000_0000, 32'hBAD0_0007, 0, 2'd0);
      push_msg(8'd1, 8'hE1, 16'h0, 32'hE000_0004, 32'h600D_0001, 1, 2'd1);
      wait_count("src_count", 16'd1, 40);
      repeat (4) @(negedge clk);
      #2;
      chk("src_count_hold", rx_count_o, 16'd1);
      chk("src_err_set", err_o, 1);
      @(negedge clk);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      #2;
      chk("err_cleared", err_o, 0);
      @(negedge clk);
      push_msg(8'd9, 8'hE9, 16'h0, 32'hE000_0008, 32'hBAD0_0009, 0, 2'd0);
      err_clr_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      err_clr_i = 1'b0;
      #2;
      chk("err_set_wins", err_o, 1);
      chk("drop_no_valid", msg_valid_o, 0);
      @(negedge clk);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      push_msg(8'd0, 8'hE0, 16'h8000, 32'hE000_000C, 32'h600D_0002, 1, 2'd0);
      wait_count("rsv_count", 16'd2, 40);
      chk("rsv_err", err_o, 1);
`else
      // unchecked build: out-of-range source is truncated and delivered, err stays 0
      @(negedge clk);
      err_clr_i = 1'b0;
      push_msg(8'd7, 8'hE7, 16'h8000, 32'hE000_0000, 32'h0000_0007, 1, 2'd3);
      wait_count("nochk_count", 16'd1, 40);
      chk("nochk_err", err_o, 0);
`endif

      // asynchronous reset while holding a message
      @(negedge clk);
      msg_ready_i = 1'b0;
      push_msg(8'd1, 8'hF1, 16'h0, 32'hF000_0000, 32'h0000_00F1, 1, 2'd1);
      push_msg(8'd2, 8'hF2, 16'h0, 32'hF000_0004, 32'h0000_00F2, 1, 2'd2);
      push_msg(8'd3, 8'hF3, 16'h0, 32'hF000_0008, 32'h0000_00F3, 1, 2'd3);
      wait_valid("rst_valid", 20);
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      void'(exp_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      msg_ready_i = 1'b1;
      wait_count("rst_resume", 16'd2, 60);
      repeat (3) @(negedge clk);
      chk("end_exp_empty", exp_q.size(), 0);
      chk("end_fifo_empty", fifo_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
